// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared constants for the bit-serial add/subtract sequencer.
//   - FSM state encoding (2-bit, legacy-compatible localparams)
//   - Operation mode encoding (add / subtract)
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RUN  = 2'd1;
    localparam state_t S_DONE = 2'd2;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage : serial_adder_pkg

// File: rtl/full_adder_s.sv
// -----------------------------------------------------------------------------
// full_adder_s
//   Single-bit combinational full adder used by the serial sequencer.
//   Ports:
//     a, b          in   operand bits
//     input_carry   in   carry into this bit
//     sum           out  a ^ b ^ input_carry
//     output_carry  out  carry out of this bit
// -----------------------------------------------------------------------------
module full_adder_s (
    input  logic a,
    input  logic b,
    input  logic input_carry,
    output logic sum,
    output logic output_carry
);

    logic w_prop;

    assign w_prop       = a ^ b;
    assign sum          = w_prop ^ input_carry;
    assign output_carry = (a & b) | (input_carry & w_prop);

endmodule : full_adder_s

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial add/subtract unit. On an accepted start the operands are
//   latched, then one bit pair per clock (LSB first) passes through a single
//   1-bit full adder. Sum bits are shifted into the result from the MSB end,
//   so after WIDTH bits the result register holds the full word.
//   Subtraction is done as a + ~b + ~borrow_in; the final carry is inverted
//   to report a borrow.
//   Ports:
//     clk        in   rising-edge clock
//     rst        in   synchronous reset, active-high
//     start      in   request, sampled only while idle
//     mode       in   0 = add, 1 = subtract (sampled with start)
//     op_a/op_b  in   WIDTH-bit operands (sampled with start)
//     carry_in   in   carry-in (add) / borrow-in (subtract)
//     busy       out  high whenever the FSM is not idle
//     done       out  one-cycle pulse, result fields valid
//     result     out  sum/difference, held until next accepted start
//     carry_out  out  carry out (add) / borrow out (subtract)
//     overflow   out  signed overflow
//   Latency: start in cycle 0 -> done in cycle WIDTH+1, next start in WIDTH+2.
// -----------------------------------------------------------------------------
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_mode;
    logic [CW-1:0]    r_count;
    logic             r_carry_out;
    logic             r_overflow;

    logic             w_sum;
    logic             w_cout;
    logic             w_last_bit;

    full_adder_s u_fa (
        .a            (r_sh_a[0]),
        .b            (r_sh_b[0]),
        .input_carry  (r_carry),
        .sum          (w_sum),
        .output_carry (w_cout)
    );

    assign w_last_bit = (r_count == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sh_a      <= '0;
            r_sh_b      <= '0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_mode      <= 1'b0;
            r_count     <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sh_a      <= op_a;
                        // Subtract as a + ~b + ~borrow_in.
                        r_sh_b      <= (mode == MODE_SUB) ? ~op_b : op_b;
                        r_carry     <= (mode == MODE_SUB) ? ~carry_in : carry_in;
                        r_mode      <= mode;
                        r_count     <= '0;
                        r_result    <= '0;
                        r_carry_out <= 1'b0;
                        r_overflow  <= 1'b0;
                        r_state     <= S_RUN;
                    end
                end

                S_RUN: begin
                    r_sh_a   <= {1'b0, r_sh_a[WIDTH-1:1]};
                    r_sh_b   <= {1'b0, r_sh_b[WIDTH-1:1]};
                    // Sum enters at the MSB; after WIDTH shifts bit 0 lands at LSB.
                    r_result <= {w_sum, r_result[WIDTH-1:1]};
                    r_carry  <= w_cout;
                    r_count  <= r_count + CW'(1);
                    if (w_last_bit) begin
                        // r_carry is the carry into the MSB at this point.
                        r_overflow  <= r_carry ^ w_cout;
                        r_carry_out <= (r_mode == MODE_SUB) ? ~w_cout : w_cout;
                        r_state     <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    // Unused encoding recovers to idle.
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;

endmodule : serial_adder_ctrl
